mem_streams_reader: RTL
=======================

# mem_streams_reader

Read-side controller and serializer for the multi-channel stream buffer. On a start pulse it reads one block of `BLOCK_LEN` parallel words, `CHANNELS` lanes each, from the buffer. Reads are issued with credit-based flow control that covers the buffer's read latency. Each returned parallel word is emitted as a channel-serial, ready/valid stream (lane 0 first) toward the PUSCH beam/MAC stages.

## Interface
- `CHANNELS`, 16, lanes per parallel word; power of 2, ≥2
- `DATA_WIDTH`, 64, bits per lane
- `BLOCK_LEN`, 1024, parallel words per block; ≥1
- `RD_LATENCY`, 3, cycles from `o_rd_ren` high to the matching `i_tvalid` high
- `BUF_DEPTH`, 8, internal word buffer depth; power of 2, ≥ `RD_LATENCY`+2
- `i_clk` in 1: sole clock
- `i_reset` in 1: asynchronous, active-high reset
- `i_start` in 1: one-cycle pulse that starts a block read; ignored while `o_busy`=1
- `o_busy` in/out: out 1: high from the cycle after an accepted start until the `o_eop` beat is accepted
- `o_rd_ren` out 1: read strobe to the stream buffer, one word per high cycle
- `i_rd_data` in `CHANNELS`×`DATA_WIDTH`: returned parallel word
- `i_tvalid` in 1: `i_rd_data` valid this cycle
- `o_data` out `DATA_WIDTH`: current lane
- `o_chn` out `$clog2(CHANNELS)`: lane index of `o_data`
- `o_valid` out 1: output beat valid
- `i_ready` in 1: downstream accepts the beat when `o_valid` & `i_ready`
- `o_sop` out 1: beat is word 0, lane 0 of the block
- `o_eop` out 1: beat is word `BLOCK_LEN`-1, lane `CHANNELS`-1
- `o_err` out 1: sticky protocol error (see Configuration)

## Operation
- FSM states:
  - IDLE → RUN on `i_start`.
  - RUN → DRAIN on the cycle the `BLOCK_LEN`-th `o_rd_ren` is issued.
  - DRAIN → IDLE when the `o_eop` beat is accepted.
- Counters: `issued` (0..`BLOCK_LEN`), `outstanding` (reads issued and not yet returned), `occ` (buffer occupancy), `lane` (0..`CHANNELS`-1), `word_out` (0..`BLOCK_LEN`-1).
- Read issue:
  - `o_rd_ren`=1 only in RUN, and only when `issued` < `BLOCK_LEN` and `outstanding` + `occ` < `BUF_DEPTH`.
  - An issue and a return in the same cycle leave `outstanding` unchanged.
- Return path: `i_tvalid` with `outstanding` > 0 writes `i_rd_data` into the buffer at the write pointer and decrements `outstanding`. Overflow cannot occur under the credit rule.
- Serializer:
  - The head word is presented lane by lane; `o_data` = head[`lane`].
  - Each accepted beat increments `lane`.
  - Accepting lane `CHANNELS`-1 wraps `lane` to 0, pops the head (`occ`−1) and increments `word_out`.
  - A push and a pop in the same cycle leave `occ` unchanged.
- Buffer pointers wrap modulo `BUF_DEPTH`.
- Stall: while `o_valid` & !`i_ready`, `o_data`, `o_chn`, `o_sop` and `o_eop` hold stable.
- `i_start` in RUN or DRAIN: ignored; no state change.
- Reset at any time:
  - All counters and pointers clear and the FSM returns to IDLE.
  - In-flight returns after reset are dropped. They are flagged only if checking is enabled.

## Timing
- Reset values: `o_busy`=0, `o_rd_ren`=0, `o_valid`=0, `o_data`=0, `o_chn`=0, `o_sop`=0, `o_eop`=0, `o_err`=0.
- `i_start` at cycle T → `o_busy`=1 and first `o_rd_ren`=1 at T+1.
- Without back-pressure, `o_rd_ren` is issued continuously until `BUF_DEPTH` credits are consumed.
- Output latency: a word written at cycle W (empty buffer) appears as `o_valid`=1, lane 0, at W+1. All outputs are registered.
- Steady state with `i_ready`=1: one beat per cycle. Each word takes `CHANNELS` cycles, so reads settle to one per `CHANNELS` cycles.
- `o_busy` falls the cycle after the `o_eop` beat is accepted. A new `i_start` is accepted in that same cycle.

## Configuration
- Macro: `MEM_STREAMS_READER_CHK_EN`.
- Defined — `o_err` sets, and holds until reset, on any of:
  - `i_tvalid` while `outstanding`=0;
  - `i_tvalid` while `occ`=`BUF_DEPTH`;
  - `i_start` while `o_busy`=1.

  The offending data is dropped.
- Undefined: `o_err` is tied to 0. The same data is dropped silently and no check logic is synthesized.

## Test plan
- CHANNELS=4, BLOCK_LEN=3, `i_ready`=1, lane data = word·16+lane, `i_start` at cycle 10 → `o_rd_ren` at 11; 12 beats with `o_chn` 0,1,2,3 repeating; `o_sop` on the first beat, `o_eop` on beat 12; `o_busy` drops after beat 12.
- `i_ready`=0 for 40 cycles mid-block → `o_rd_ren` count stops at `BUF_DEPTH` outstanding+buffered; beats resume in order with no loss or duplicate.
- Toggle `i_ready` randomly → stall holds `o_data`/`o_chn` stable; the output sequence exactly matches the source order.
- Pulse `i_start` during RUN → no effect on the count (3 words read); with `MEM_STREAMS_READER_CHK_EN`, `o_err`=1.
- Stray `i_tvalid` in IDLE → no output beat; `o_err`=1 only with the macro defined.
- Assert `i_reset` asynchronously mid-block → all outputs are 0 immediately; a following `i_start` reads a full fresh block correctly.

Source files
------------

// File: rtl/mem_streams_reader.sv
// -----------------------------------------------------------------------------
// mem_streams_reader
//
// Read-side controller and serializer for the multi-channel stream buffer.
// When i_start is pulsed, the block reads BLOCK_LEN parallel words (CHANNELS
// lanes each) from the stream buffer. It then emits every word as a
// channel-serial stream, lane 0 first.
//
// Read issue uses credits. A read is issued only while
// (reads in flight + words held locally) < BUF_DEPTH. This guarantees that
// every return has a free slot, whatever the buffer read latency is.
//
// Ports
//   i_clk      sole clock
//   i_reset    asynchronous, active-high reset
//   i_start    one-cycle start pulse; ignored while o_busy=1
//   o_busy     high from the cycle after an accepted start until the cycle
//              after the o_eop beat is accepted
//   o_rd_ren   read strobe to the stream buffer, one word per high cycle
//   i_rd_data  returned parallel word, lane n at bits [n*DATA_WIDTH +: DATA_WIDTH]
//   i_tvalid   i_rd_data valid this cycle
//   o_data     current lane data
//   o_chn      lane index of o_data
//   o_valid    output beat valid
//   i_ready    downstream ready
//   o_sop      beat is word 0, lane 0 of the block
//   o_eop      beat is word BLOCK_LEN-1, lane CHANNELS-1
//   o_err      sticky protocol error
//
// Output handshake: a beat transfers on every rising edge where
// o_valid & i_ready are both high. While o_valid=1 and i_ready=0, the
// o_data, o_chn, o_sop and o_eop outputs hold stable. o_valid never drops
// before its beat transfers.
//
// Build option: define MEM_STREAMS_READER_CHK_EN to enable the protocol
// checks behind o_err. These flag a return with nothing outstanding, a return
// into a full buffer, and a start while busy. Without the define, o_err is
// tied to 0. In both builds the offending return data is dropped.
// -----------------------------------------------------------------------------
module mem_streams_reader #(
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 64,
  parameter int BLOCK_LEN  = 1024,
  parameter int RD_LATENCY = 3,
  parameter int BUF_DEPTH  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  output logic                           o_busy,
  output logic                           o_rd_ren,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_rd_data,
  input  logic                           i_tvalid,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [$clog2(CHANNELS)-1:0]    o_chn,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_sop,
  output logic                           o_eop,
  output logic                           o_err
);

  localparam int WORD_W = CHANNELS * DATA_WIDTH;
  localparam int LW     = $clog2(CHANNELS);
  localparam int IW     = $clog2(BLOCK_LEN + 1);
  localparam int WW     = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int OW     = $clog2(BUF_DEPTH + 1);
  localparam int PW     = $clog2(BUF_DEPTH);

  localparam logic [IW-1:0] BLOCK_C    = IW'(BLOCK_LEN);
  localparam logic [IW-1:0] LAST_ISSUE = IW'(BLOCK_LEN - 1);
  localparam logic [WW-1:0] LAST_WORD  = WW'(BLOCK_LEN - 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(CHANNELS - 1);
  localparam logic [OW-1:0] FULL_C     = OW'(BUF_DEPTH);
  localparam logic [OW:0]   DEPTH_C    = (OW+1)'(BUF_DEPTH);

  // Fewer slots than the read latency plus head/turnaround would throttle
  // the read stream below one word per cycle during the initial fill.
  if (BUF_DEPTH < RD_LATENCY + 2) begin : g_depth_check
    $error("mem_streams_reader: BUF_DEPTH must be >= RD_LATENCY+2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   issued, issued_n;
  logic [OW-1:0]   outstanding, outstanding_n;
  logic [OW-1:0]   occ, occ_n;
  logic [PW-1:0]   wr_ptr, wr_ptr_n;
  logic [PW-1:0]   rd_ptr, rd_ptr_n;
  logic [LW-1:0]   lane, lane_n;
  logic [WW-1:0]   word_out, word_out_n;
  logic [OW:0]     credits_n;
  logic [WORD_W-1:0] mem [BUF_DEPTH];
  logic [WORD_W-1:0] head_n;

  logic accept, pop, push, start_ok, last_beat;
  logic rd_ren_n, valid_n, sop_n, eop_n;
  logic [DATA_WIDTH-1:0] data_n;

  assign o_busy = (state != S_IDLE);

  // Next-state and next-output computation. Every output register is loaded
  // from the post-edge view of the counters. This lets a word written into
  // an empty buffer appear as lane 0 on the very next cycle.
  always_comb begin
    accept    = o_valid & i_ready;
    pop       = accept & (lane == LAST_LANE);
    last_beat = accept & o_eop;
    // A return lands only if a read is outstanding and a slot is free.
    // Anything else is a stray and is dropped.
    push      = i_tvalid && (outstanding != '0) && (occ != FULL_C);
    start_ok  = i_start && (state == S_IDLE);

    state_n = state;
    case (state)
      S_IDLE:  if (start_ok) state_n = S_RUN;
      S_RUN:   if (o_rd_ren && (issued == LAST_ISSUE)) state_n = S_DRAIN;
      S_DRAIN: if (last_beat) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    issued_n      = start_ok ? '0 : issued + IW'(o_rd_ren);
    outstanding_n = outstanding + OW'(o_rd_ren) - OW'(push);
    occ_n         = occ + OW'(push) - OW'(pop);
    wr_ptr_n      = wr_ptr + PW'(push);
    rd_ptr_n      = rd_ptr + PW'(pop);
    lane_n        = lane + LW'(accept);

    word_out_n = word_out;
    if (last_beat)
      word_out_n = '0;
    else if (pop)
      word_out_n = word_out + WW'(1);

    credits_n = {1'b0, outstanding_n} + {1'b0, occ_n};
    rd_ren_n  = (state_n == S_RUN) && (issued_n < BLOCK_C) && (credits_n < DEPTH_C);

    // The next head can be the entry being written this cycle, but only when
    // the buffer drains to empty. Otherwise rd_ptr_n never equals wr_ptr.
    head_n  = (push && (rd_ptr_n == wr_ptr)) ? i_rd_data : mem[rd_ptr_n];
    valid_n = (occ_n != '0);
    data_n  = valid_n ? head_n[lane_n*DATA_WIDTH +: DATA_WIDTH] : '0;
    sop_n   = valid_n && (word_out_n == '0) && (lane_n == '0);
    eop_n   = valid_n && (word_out_n == LAST_WORD) && (lane_n == LAST_LANE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      issued      <= '0;
      outstanding <= '0;
      occ         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      lane        <= '0;
      word_out    <= '0;
      o_rd_ren    <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_chn       <= '0;
      o_sop       <= 1'b0;
      o_eop       <= 1'b0;
    end else begin
      state       <= state_n;
      issued      <= issued_n;
      outstanding <= outstanding_n;
      occ         <= occ_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      lane        <= lane_n;
      word_out    <= word_out_n;
      o_rd_ren    <= rd_ren_n;
      o_valid     <= valid_n;
      o_data      <= data_n;
      o_chn       <= lane_n;
      o_sop       <= sop_n;
      o_eop       <= eop_n;
    end
  end

  // Word storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_rd_data;
  end

`ifdef MEM_STREAMS_READER_CHK_EN
  logic err_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      err_q <= 1'b0;
    else if ((i_tvalid && ((outstanding == '0) || (occ == FULL_C))) ||
             (i_start && (state != S_IDLE)))
      err_q <= 1'b1;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
